id_ex_ctrl_stage: RTL and testbench
===================================

Name: id_ex_ctrl_stage

Overview:
ID-side producer of the EX-stage ALU-control inputs (ALUOp, funct7 bit, funct3). It also registers the rest of the pipeline control word.
- Decodes the ID instruction into main-control signals and the immediate.
- Registers them into the ID/EX pipeline register.
- Detects load-use hazards and inserts bubbles.
- Its registered outputs drive the ALU control decoder and the ALU in EX directly.

Parameters:
XLEN, 32, datapath/immediate width.
REG_ADDR_W, 5, register index width.

Ports:
clk  input  1  clock, rising edge.
rst  input  1  asynchronous, active-high reset.
id_valid  input  1  ID holds a real instruction.
id_instr  input  32  instruction in ID.
flush  input  1  branch-taken squash of ID/EX contents.
stall_in  input  1  downstream stall; hold ID/EX.
ex_valid  output  1  EX holds a real instruction.
ex_alu_op  output  2  00 lw/sw (add), 01 beq (sub), 10 R-type (funct decode).
ex_funct7_bit_6  output  1  instr[30] of the registered instruction.
ex_funct3  output  3  instr[14:12].
ex_rs1, ex_rs2, ex_rd  output  REG_ADDR_W  register indices.
ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_alu_src, ex_mem_to_reg  output  1 each  main control.
ex_imm  output  XLEN  sign-extended immediate.
hazard_stall  output  1  combinational; hold PC and IF/ID this cycle.
illegal_instr  output  1  registered; unsupported opcode captured with id_valid=1.

Behaviour:
- Reset (async, rst=1): every ex_* output = 0, ex_valid=0, illegal_instr=0. hazard_stall is 0 while rst=1.
- Decode (combinational), controls listed in port order reg_write/mem_read/mem_write/branch/alu_src/mem_to_reg:
  - R 0110011: ALUOp=10, controls 1/0/0/0/0/0, uses rs1+rs2, imm=0.
  - lw 0000011: ALUOp=00, controls 1/1/0/0/1/1, uses rs1, imm=sext(instr[31:20]).
  - sw 0100011: ALUOp=00, controls 0/0/1/0/1/0, uses rs1+rs2, imm=sext({instr[31:25],instr[11:7]}).
  - beq 1100011: ALUOp=01, controls 0/0/0/1/0/0, uses rs1+rs2, imm=sext({instr[31],instr[7],instr[30:25],instr[11:8],1'b0}).
  - Any other opcode: all controls 0, ALUOp=00, imm=0, illegal=1.
- hazard = ex_valid & ex_mem_read & ex_rd!=0 & id_valid & ((uses_rs1 & ex_rd==id rs1) | (uses_rs2 & ex_rd==id rs2)).
- hazard_stall = hazard & !flush (rst=0).
- Register update at rising edge, priority order:
  1. flush: load bubble. ex_valid=0, all controls/ALUOp/imm/indices 0, illegal 0.
  2. stall_in: hold all registers unchanged. hazard_stall still reflects current compare.
  3. hazard: load bubble, the same as flush.
  4. Otherwise: capture decode. ex_valid=id_valid. When id_valid=0, load bubble.
- Latency: exactly 1 cycle from ID to EX outputs. Bubble-on-hazard resolves a load-use hazard after exactly one inserted bubble; the following cycle compares against a bubble and proceeds.
- A bubble never asserts reg_write, mem_write or branch.
- x0 as rd never causes a hazard.
- Reset asserted mid-stall clears immediately. First edge after release captures normally.

Decomposition:
- Package riscv_ctrl_pkg:
  - opcode localparams (OP_R, OP_LOAD, OP_STORE, OP_BRANCH).
  - ALUOp enum (ALUOP_MEM=2'b00, ALUOP_BRANCH=2'b01, ALUOP_RTYPE=2'b10).
  - packed struct ctrl_t holding the six control bits plus alu_op.
  - the BUBBLE_CTRL constant.
- One combinational sub-module, id_main_decoder. Input: instr. Outputs: ctrl_t, imm, uses_rs1, uses_rs2, illegal.
- The top holds the register, priority mux and hazard compare.

Test Plan:
- Reset then add x3,x1,x2 (0x002081B3), id_valid=1 -> next edge:
  - ex_alu_op=10, funct3=000, ex_funct7_bit_6=0.
  - ex_rd=3, reg_write=1, ex_valid=1.
- sub x3,x1,x2 (0x402081B3) -> ex_funct7_bit_6=1, ex_alu_op=10.
- sw x2,-4(x1) (0xFE20AE23) -> ex_imm=0xFFFFFFFC, mem_write=1, alu_src=1, ex_alu_op=00.
- beq x1,x2,-8 (0xFE208CE3) -> ex_imm=0xFFFFFFF8, branch=1, ex_alu_op=01.
- Load-use: lw x5,8(x1) (0x00A0A283 variant: use 0x0080A283, rd=5) then add x6,x5,x2 (0x00228333):
  - hazard_stall=1 for one cycle, EX gets a bubble (ex_valid=0).
  - Next cycle hazard_stall=0 and the add is captured.
- Priority and reset:
  - flush with stall_in, then stall_in alone -> flush wins (bubble). stall_in alone holds EX values for 3 cycles.
  - rst pulsed mid-hold -> all outputs 0 asynchronously.
  - Opcode 0x7F -> illegal_instr=1, all controls 0.

Source files
------------

// File: rtl/id_ex_ctrl_stage_pkg.sv
// Shared definitions for the ID/EX control stage.
//   OP_*        : RV32I opcodes handled by the main decoder
//   alu_op_e    : ALUOp encoding consumed by the EX-stage ALU control decoder
//   ctrl_t      : main-control word carried through ID/EX
//   BUBBLE_CTRL : control word of an inserted bubble (no side effects)
package riscv_ctrl_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {
    ALUOP_MEM    = 2'b00,
    ALUOP_BRANCH = 2'b01,
    ALUOP_RTYPE  = 2'b10
  } alu_op_e;

  typedef struct packed {
    logic    reg_write;
    logic    mem_read;
    logic    mem_write;
    logic    branch;
    logic    alu_src;
    logic    mem_to_reg;
    alu_op_e alu_op;
  } ctrl_t;

  localparam ctrl_t BUBBLE_CTRL = '{
    reg_write:  1'b0,
    mem_read:   1'b0,
    mem_write:  1'b0,
    branch:     1'b0,
    alu_src:    1'b0,
    mem_to_reg: 1'b0,
    alu_op:     ALUOP_MEM
  };

endpackage

// File: rtl/id_ex_ctrl_stage_if.sv
// ID/EX control-stage bus.
//   ID side  : id_valid, id_instr, flush, stall_in
//   EX side  : ex_valid, ex_alu_op, ex_funct7_bit_6, ex_funct3, ex_rs1/rs2/rd,
//              main-control bits, ex_imm
//   status   : hazard_stall (combinational), illegal_instr (registered)
// master = pipeline driving ID, slave = the control stage.
interface id_ex_ctrl_stage_if #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned REG_ADDR_W = 5
);
  logic                  id_valid;
  logic [31:0]           id_instr;
  logic                  flush;
  logic                  stall_in;

  logic                  ex_valid;
  logic [1:0]            ex_alu_op;
  logic                  ex_funct7_bit_6;
  logic [2:0]            ex_funct3;
  logic [REG_ADDR_W-1:0] ex_rs1;
  logic [REG_ADDR_W-1:0] ex_rs2;
  logic [REG_ADDR_W-1:0] ex_rd;
  logic                  ex_reg_write;
  logic                  ex_mem_read;
  logic                  ex_mem_write;
  logic                  ex_branch;
  logic                  ex_alu_src;
  logic                  ex_mem_to_reg;
  logic [XLEN-1:0]       ex_imm;
  logic                  hazard_stall;
  logic                  illegal_instr;

  modport master (
    output id_valid, id_instr, flush, stall_in,
    input  ex_valid, ex_alu_op, ex_funct7_bit_6, ex_funct3, ex_rs1, ex_rs2, ex_rd,
           ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_alu_src,
           ex_mem_to_reg, ex_imm, hazard_stall, illegal_instr
  );

  modport slave (
    input  id_valid, id_instr, flush, stall_in,
    output ex_valid, ex_alu_op, ex_funct7_bit_6, ex_funct3, ex_rs1, ex_rs2, ex_rd,
           ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_alu_src,
           ex_mem_to_reg, ex_imm, hazard_stall, illegal_instr
  );

endinterface

// File: rtl/id_ex_ctrl_stage_main_decoder.sv
// Combinational main decoder for the ID instruction.
//   instr        : 32-bit instruction in ID
//   ctrl         : main-control word (six control bits + ALUOp)
//   imm          : sign-extended immediate (0 for R-type / unsupported)
//   uses_rs1/2   : source registers actually read (hazard qualification)
//   illegal      : opcode not supported
//   rs1/rs2/rd, funct3, funct7_bit_6 : raw instruction fields
import riscv_ctrl_pkg::*;

module id_main_decoder #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic [31:0]           instr,
  output ctrl_t                 ctrl,
  output logic [XLEN-1:0]       imm,
  output logic                  uses_rs1,
  output logic                  uses_rs2,
  output logic                  illegal,
  output logic [REG_ADDR_W-1:0] rs1,
  output logic [REG_ADDR_W-1:0] rs2,
  output logic [REG_ADDR_W-1:0] rd,
  output logic [2:0]            funct3,
  output logic                  funct7_bit_6
);

  assign rs1          = REG_ADDR_W'(instr[19:15]);
  assign rs2          = REG_ADDR_W'(instr[24:20]);
  assign rd           = REG_ADDR_W'(instr[11:7]);
  assign funct3       = instr[14:12];
  assign funct7_bit_6 = instr[30];

  always_comb begin
    ctrl     = BUBBLE_CTRL;
    imm      = '0;
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;
    illegal  = 1'b0;
    case (instr[6:0])
      OP_R: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_op    = ALUOP_RTYPE;
        uses_rs1       = 1'b1;
        uses_rs2       = 1'b1;
      end
      OP_LOAD: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_read   = 1'b1;
        ctrl.alu_src    = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        uses_rs1        = 1'b1;
        imm             = {{(XLEN-12){instr[31]}}, instr[31:20]};
      end
      OP_STORE: begin
        ctrl.mem_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        uses_rs1       = 1'b1;
        uses_rs2       = 1'b1;
        imm            = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
      end
      OP_BRANCH: begin
        ctrl.branch = 1'b1;
        ctrl.alu_op = ALUOP_BRANCH;
        uses_rs1    = 1'b1;
        uses_rs2    = 1'b1;
        imm         = {{(XLEN-12){instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/id_ex_ctrl_stage.sv
// ID/EX pipeline register for the control word, with load-use hazard
// detection and bubble insertion.
//   clk, rst : rising-edge clock, asynchronous active-high reset
//   bus      : id_ex_ctrl_stage_if.slave (ID inputs, EX outputs, hazard_stall,
//              illegal_instr)
import riscv_ctrl_pkg::*;

module id_ex_ctrl_stage #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned REG_ADDR_W = 5
) (
  input logic                clk,
  input logic                rst,
  id_ex_ctrl_stage_if.slave  bus
);

  ctrl_t                 dec_ctrl;
  logic [XLEN-1:0]       dec_imm;
  logic                  dec_uses_rs1;
  logic                  dec_uses_rs2;
  logic                  dec_illegal;
  logic [REG_ADDR_W-1:0] dec_rs1;
  logic [REG_ADDR_W-1:0] dec_rs2;
  logic [REG_ADDR_W-1:0] dec_rd;
  logic [2:0]            dec_funct3;
  logic                  dec_funct7_bit_6;

  id_main_decoder #(
    .XLEN       (XLEN),
    .REG_ADDR_W (REG_ADDR_W)
  ) u_dec (
    .instr        (bus.id_instr),
    .ctrl         (dec_ctrl),
    .imm          (dec_imm),
    .uses_rs1     (dec_uses_rs1),
    .uses_rs2     (dec_uses_rs2),
    .illegal      (dec_illegal),
    .rs1          (dec_rs1),
    .rs2          (dec_rs2),
    .rd           (dec_rd),
    .funct3       (dec_funct3),
    .funct7_bit_6 (dec_funct7_bit_6)
  );

  logic                  ex_valid_q;
  ctrl_t                 ex_ctrl_q;
  logic                  ex_funct7_q;
  logic [2:0]            ex_funct3_q;
  logic [REG_ADDR_W-1:0] ex_rs1_q;
  logic [REG_ADDR_W-1:0] ex_rs2_q;
  logic [REG_ADDR_W-1:0] ex_rd_q;
  logic [XLEN-1:0]       ex_imm_q;
  logic                  illegal_q;

  logic hazard;
  logic load_bubble;
  logic update;

  // Load in EX whose destination is read by the instruction in ID.
  always_comb begin
    hazard = ex_valid_q && ex_ctrl_q.mem_read && (ex_rd_q != '0) && bus.id_valid &&
             ((dec_uses_rs1 && (ex_rd_q == dec_rs1)) ||
              (dec_uses_rs2 && (ex_rd_q == dec_rs2)));
  end

  // Priority flush > stall_in > hazard > capture folded into two terms:
  // the register updates unless stalled (flush overrides the stall), and the
  // update is a bubble on flush, hazard or an empty ID slot.
  assign update      = bus.flush || !bus.stall_in;
  assign load_bubble = bus.flush || hazard || !bus.id_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid_q  <= 1'b0;
      ex_ctrl_q   <= BUBBLE_CTRL;
      ex_funct7_q <= 1'b0;
      ex_funct3_q <= '0;
      ex_rs1_q    <= '0;
      ex_rs2_q    <= '0;
      ex_rd_q     <= '0;
      ex_imm_q    <= '0;
      illegal_q   <= 1'b0;
    end else if (update) begin
      if (load_bubble) begin
        ex_valid_q  <= 1'b0;
        ex_ctrl_q   <= BUBBLE_CTRL;
        ex_funct7_q <= 1'b0;
        ex_funct3_q <= '0;
        ex_rs1_q    <= '0;
        ex_rs2_q    <= '0;
        ex_rd_q     <= '0;
        ex_imm_q    <= '0;
        illegal_q   <= 1'b0;
      end else begin
        ex_valid_q  <= 1'b1;
        ex_ctrl_q   <= dec_ctrl;
        ex_funct7_q <= dec_funct7_bit_6;
        ex_funct3_q <= dec_funct3;
        ex_rs1_q    <= dec_rs1;
        ex_rs2_q    <= dec_rs2;
        ex_rd_q     <= dec_rd;
        ex_imm_q    <= dec_imm;
        illegal_q   <= dec_illegal;
      end
    end
  end

  assign bus.ex_valid        = ex_valid_q;
  assign bus.ex_alu_op       = ex_ctrl_q.alu_op;
  assign bus.ex_funct7_bit_6 = ex_funct7_q;
  assign bus.ex_funct3       = ex_funct3_q;
  assign bus.ex_rs1          = ex_rs1_q;
  assign bus.ex_rs2          = ex_rs2_q;
  assign bus.ex_rd           = ex_rd_q;
  assign bus.ex_reg_write    = ex_ctrl_q.reg_write;
  assign bus.ex_mem_read     = ex_ctrl_q.mem_read;
  assign bus.ex_mem_write    = ex_ctrl_q.mem_write;
  assign bus.ex_branch       = ex_ctrl_q.branch;
  assign bus.ex_alu_src      = ex_ctrl_q.alu_src;
  assign bus.ex_mem_to_reg   = ex_ctrl_q.mem_to_reg;
  assign bus.ex_imm          = ex_imm_q;
  assign bus.illegal_instr   = illegal_q;
  assign bus.hazard_stall    = !rst && hazard && !bus.flush;

endmodule

// File: tb/tb_id_ex_ctrl_stage.sv
// Directed scoreboard bench for id_ex_ctrl_stage.
module tb_id_ex_ctrl_stage;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  id_ex_ctrl_stage_if bus ();

  id_ex_ctrl_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic        valid;
    logic [1:0]  alu_op;
    logic        f7;
    logic [2:0]  f3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        rw;
    logic        mr;
    logic        mw;
    logic        br;
    logic        as;
    logic        m2r;
    logic [31:0] imm;
    logic        ill;
  } exp_t;

  int   compared   = 0;
  int   mismatched = 0;
  exp_t sb_q[$];
  exp_t cur = '0;

  function automatic exp_t observe();
    exp_t o;
    o.valid = bus.ex_valid;
    o.alu_op = bus.ex_alu_op;
    o.f7 = bus.ex_funct7_bit_6;
    o.f3 = bus.ex_funct3;
    o.rs1 = bus.ex_rs1;
    o.rs2 = bus.ex_rs2;
    o.rd = bus.ex_rd;
    o.rw = bus.ex_reg_write;
    o.mr = bus.ex_mem_read;
    o.mw = bus.ex_mem_write;
    o.br = bus.ex_branch;
    o.as = bus.ex_alu_src;
    o.m2r = bus.ex_mem_to_reg;
    o.imm = bus.ex_imm;
    o.ill = bus.illegal_instr;
    return o;
  endfunction

  // Reference EX contents for a valid instruction captured from ID.
  function automatic exp_t ref_ex(input logic [31:0] ins);
    exp_t e = '0;
    e.valid = 1'b1;
    e.f7 = ins[30];
    e.f3 = ins[14:12];
    e.rs1 = ins[19:15];
    e.rs2 = ins[24:20];
    e.rd = ins[11:7];
    case (ins[6:0])
      7'h33: begin e.alu_op = 2'b10; e.rw = 1'b1; end
      7'h03: begin
        e.rw = 1'b1; e.mr = 1'b1; e.as = 1'b1; e.m2r = 1'b1;
        e.imm = {{20{ins[31]}}, ins[31:20]};
      end
      7'h23: begin
        e.mw = 1'b1; e.as = 1'b1;
        e.imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      end
      7'h63: begin
        e.alu_op = 2'b01; e.br = 1'b1;
        e.imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      end
      default: e.ill = 1'b1;
    endcase
    return e;
  endfunction

  function automatic logic ref_hazard(input exp_t ex, input logic [31:0] ins, input logic v);
    logic [6:0] op = ins[6:0];
    logic u1 = (op == 7'h33) || (op == 7'h03) || (op == 7'h23) || (op == 7'h63);
    logic u2 = (op == 7'h33) || (op == 7'h23) || (op == 7'h63);
    return ex.valid && ex.mr && (ex.rd != 5'd0) && v &&
           ((u1 && (ex.rd == ins[19:15])) || (u2 && (ex.rd == ins[24:20])));
  endfunction

  task automatic check_bit(input string tag, input logic obs, input logic expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, expv);
    end
  endtask

  task automatic check_vec(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Drive one ID cycle, check the combinational stall, then check EX after the edge.
  task automatic step(input logic [31:0] ins, input logic v, input logic fl, input logic st);
    exp_t nxt;
    logic hz;
    bus.id_instr = ins;
    bus.id_valid = v;
    bus.flush    = fl;
    bus.stall_in = st;
    #1;
    hz = ref_hazard(cur, ins, v);
    check_bit("hazard_stall", bus.hazard_stall, hz & ~fl);
    if (fl)            nxt = '0;
    else if (st)       nxt = cur;
    else if (hz || !v) nxt = '0;
    else               nxt = ref_ex(ins);
    sb_q.push_back(nxt);
    @(posedge clk);
    #1;
    cur = sb_q.pop_front();
    check_vec("ex_word", 64'(observe()), 64'(cur));
  endtask

  localparam logic [31:0] ADD    = 32'h002081B3;
  localparam logic [31:0] SUB    = 32'h402081B3;
  localparam logic [31:0] SW     = 32'hFE20AE23;
  localparam logic [31:0] BEQ    = 32'hFE208CE3;
  localparam logic [31:0] LW_X5  = 32'h0080A283;
  localparam logic [31:0] ADD_U5 = 32'h00228333;
  localparam logic [31:0] LW_X0  = 32'h0080A003;
  localparam logic [31:0] ADD_U0 = 32'h00200333;
  localparam logic [31:0] ILL    = 32'h0000007F;

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.id_instr = '0;
    bus.id_valid = 1'b0;
    bus.flush    = 1'b0;
    bus.stall_in = 1'b0;

    #3;
    check_vec("reset_ex_word", 64'(observe()), 64'd0);
    check_bit("reset_hazard", bus.hazard_stall, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    step(ADD, 1'b1, 1'b0, 1'b0);
    check_vec("add_alu_op", 64'(bus.ex_alu_op), 64'd2);
    check_vec("add_rd", 64'(bus.ex_rd), 64'd3);
    step(SUB, 1'b1, 1'b0, 1'b0);
    check_bit("sub_funct7", bus.ex_funct7_bit_6, 1'b1);
    step(SW, 1'b1, 1'b0, 1'b0);
    check_vec("sw_imm", 64'(bus.ex_imm), 64'hFFFF_FFFC);
    step(BEQ, 1'b1, 1'b0, 1'b0);
    check_vec("beq_imm", 64'(bus.ex_imm), 64'hFFFF_FFF8);

    // load-use: one bubble, then the dependent add proceeds
    step(LW_X5, 1'b1, 1'b0, 1'b0);
    step(ADD_U5, 1'b1, 1'b0, 1'b0);
    check_bit("loaduse_bubble_valid", bus.ex_valid, 1'b0);
    step(ADD_U5, 1'b1, 1'b0, 1'b0);
    check_bit("loaduse_after_valid", bus.ex_valid, 1'b1);

    // x0 destination never stalls
    step(LW_X0, 1'b1, 1'b0, 1'b0);
    step(ADD_U0, 1'b1, 1'b0, 1'b0);

    // flush beats stall_in and masks hazard_stall
    step(LW_X5, 1'b1, 1'b0, 1'b0);
    step(ADD_U5, 1'b1, 1'b1, 1'b1);
    step(ADD_U5, 1'b1, 1'b0, 1'b0);

    // stall_in holds a load in EX for three cycles while the hazard is visible
    step(LW_X5, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(ADD_U5, 1'b1, 1'b0, 1'b1);
    check_bit("hold_mem_read", bus.ex_mem_read, 1'b1);

    // asynchronous reset in the middle of the hold
    rst = 1'b1;
    #1;
    check_vec("midreset_ex_word", 64'(observe()), 64'd0);
    check_bit("midreset_hazard", bus.hazard_stall, 1'b0);
    cur = '0;
    sb_q.delete();
    @(negedge clk);
    rst = 1'b0;
    step(ADD, 1'b1, 1'b0, 1'b0);

    // unsupported opcode, then the same opcode with no valid instruction
    step(ILL, 1'b1, 1'b0, 1'b0);
    check_bit("illegal_flag", bus.illegal_instr, 1'b1);
    step(ILL, 1'b0, 1'b0, 1'b0);
    step(32'h0, 1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
